data_mem_responder: RTL
=======================

Name: data_mem_responder

Overview:
- Data-memory responder (slave) for the core's M-stage data port.
- Accepts word, halfword and byte reads and writes at a programmable number of wait states.
- Returns read data together with a one-cycle acknowledge on data_mem_ack_M, which releases the core's stall.
- Also flags misaligned or out-of-range accesses so the core can raise an address exception.

Parameters:
- ADDR_WIDTH, 10, log2 of memory depth in 32-bit words (default 1024 words = 4 KB).
- WAIT_CYCLES, 2, wait states between request sampling and acknowledge; legal range 0..15.
- BASE_ADDR, 32'h0000_0000, byte address of word 0; must be 4 KB-aligned for the default depth.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- reset  input  1  synchronous, active-low reset (0 = reset).
- mem_req_M  input  1  access request; held high by the core until it sees ack.
- mem_write_M  input  1  1 = write, 0 = read; sampled with mem_req_M.
- mem_size_M  input  2  00 = byte, 01 = halfword, 10 = word, 11 = illegal.
- alu_out_M  input  32  byte address.
- write_data_M  input  32  write data, already lane-replicated by the core (byte/halfword repeat).
- read_data_M  output  32  aligned 32-bit word read; the core extracts lanes.
- data_mem_ack_M  output  1  one-cycle completion pulse.
- mem_err_M  output  1  valid only with ack; 1 = misaligned, out-of-range or illegal size.

Behaviour:
- Reset (reset = 0 at an edge):
  - state goes to IDLE; counter = 0.
  - read_data_M = 0, data_mem_ack_M = 0, mem_err_M = 0.
  - Memory array is not cleared.
  - Reset mid-operation aborts the access; a pending write is not committed.
- States: IDLE, WAIT, ACK.
- IDLE:
  - On an edge with mem_req_M = 1, latch write, size, address, write data and error status.
  - If WAIT_CYCLES = 0, go to ACK; otherwise go to WAIT with counter = WAIT_CYCLES - 1.
- WAIT:
  - Counter decrements each edge; at counter = 0 the next edge enters ACK.
  - If mem_req_M drops during WAIT (protocol violation), return to IDLE with no ack and no write.
- Entering ACK (commit edge):
  - A legal write updates only the addressed lanes:
    - byte: lane = addr[1:0] (lane 0 = bits 7:0).
    - halfword: lanes {addr[1],0} and {addr[1],1}.
    - word: all lanes.
  - A legal read registers mem[word index] into read_data_M.
- ACK:
  - data_mem_ack_M = 1 for exactly one cycle; the next edge returns to IDLE unconditionally.
  - The request is not re-sampled in the ACK cycle.
  - Back-to-back accesses therefore take WAIT_CYCLES + 2 cycles each.
- Latency: ack is high in cycle WAIT_CYCLES + 1 after the sampling edge (sampling edge = cycle 0).
- read_data_M holds its value until the next read ack; writes do not change it.
- Word index = (alu_out_M - BASE_ADDR) >> 2. Out of range when the difference ≥ 4 × 2^ADDR_WIDTH (unsigned).
- Error conditions:
  - misaligned halfword (addr[0] = 1).
  - misaligned word (addr[1:0] ≠ 00).
  - size = 11.
  - out of range.
- On error:
  - Same timing, ack with mem_err_M = 1.
  - No write; read_data_M = 0.
- mem_err_M is 0 whenever ack = 0.
- mem_req_M asserted continuously from reset release: first sampling edge is the first edge with reset = 1.

Test Plan:
- WAIT_CYCLES = 2: word write 32'hDEADBEEF to 0x10 (req held), then word read 0x10 → ack 3 cycles after each sampling edge, read_data_M = 32'hDEADBEEF, err = 0.
- Byte write data 32'hAAAAAAAA at 0x11, then halfword write 32'h5555_5555 at 0x12 over a zeroed word, then word read 0x10 → 32'h5555AA00.
- Halfword read at 0x13; word write at 0x06; size 11; address 0x1000 (ADDR_WIDTH = 10) → each acks with err = 1, memory unchanged, read_data_M = 0.
- WAIT_CYCLES = 0, req held high for 3 reads → acks in cycles 1, 3, 5 (one per 2 cycles); ack never high in 2 consecutive cycles.
- Reset pulled low during WAIT of a write to 0x20 → no ack, outputs 0; a later read of 0x20 returns the old contents.
- mem_req_M dropped during WAIT → no ack, no write, state IDLE; the next request completes normally.

Source files
------------

// File: rtl/data_mem_if.sv
// Core M-stage data-memory port: request/address/data from the core, data/ack/error back.
interface data_mem_if;
   logic        mem_req_M;
   logic        mem_write_M;
   logic [1:0]  mem_size_M;
   logic [31:0] alu_out_M;
   logic [31:0] write_data_M;
   logic [31:0] read_data_M;
   logic        data_mem_ack_M;
   logic        mem_err_M;

   modport master (
      output mem_req_M, mem_write_M, mem_size_M, alu_out_M, write_data_M,
      input  read_data_M, data_mem_ack_M, mem_err_M
   );

   modport slave (
      input  mem_req_M, mem_write_M, mem_size_M, alu_out_M, write_data_M,
      output read_data_M, data_mem_ack_M, mem_err_M
   );
endinterface

// File: rtl/data_mem_responder.sv
// Data-memory slave for the M-stage port: byte/half/word access with fixed wait states,
// one-cycle ack, and error flagging for misaligned, illegal-size or out-of-range accesses.
module data_mem_responder #(
   parameter int unsigned ADDR_WIDTH  = 10,
   parameter int unsigned WAIT_CYCLES = 2,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
   input  logic       clk,
   input  logic       reset,
   data_mem_if.slave  bus
);

   localparam int unsigned DEPTH = 32'(1) << ADDR_WIDTH;
   localparam int unsigned CW    = 4;
   localparam logic [32:0] SPAN  = 33'(DEPTH) << 2;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_e;

   state_e                  state_q, state_d;
   logic [CW-1:0]           cnt_q, cnt_d;
   logic                    wr_q, wr_d;
   logic [3:0]              be_q, be_d;
   logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
   logic [31:0]             wdata_q, wdata_d;
   logic                    lerr_q, lerr_d;
   logic [31:0]             rdata_q, rdata_d;
   logic                    ack_q, ack_d;
   logic                    merr_q, merr_d;
   logic                    mem_we_c;

   logic [31:0]             mem [DEPTH];

   logic [31:0]             diff_c;
   logic                    oor_c;
   logic                    bad_c;
   logic [3:0]              be_c;

   // Decode the incoming request: lane enables and error status.
   always_comb begin
      diff_c = bus.alu_out_M - BASE_ADDR;
      oor_c  = {1'b0, diff_c} >= SPAN;
      be_c   = 4'b0000;
      bad_c  = 1'b0;
      unique case (bus.mem_size_M)
         2'b00: be_c = 4'(4'b0001 << bus.alu_out_M[1:0]);
         2'b01: begin
            be_c  = bus.alu_out_M[1] ? 4'b1100 : 4'b0011;
            bad_c = bus.alu_out_M[0];
         end
         2'b10: begin
            be_c  = 4'b1111;
            bad_c = (bus.alu_out_M[1:0] != 2'b00);
         end
         default: bad_c = 1'b1;
      endcase
   end

   // Next state, request latch and commit on the edge that enters ACK.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      wr_d     = wr_q;
      be_d     = be_q;
      idx_d    = idx_q;
      wdata_d  = wdata_q;
      lerr_d   = lerr_q;
      rdata_d  = rdata_q;
      ack_d    = 1'b0;
      merr_d   = 1'b0;
      mem_we_c = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (bus.mem_req_M) begin
               wr_d    = bus.mem_write_M;
               be_d    = be_c;
               idx_d   = diff_c[ADDR_WIDTH+1:2];
               wdata_d = bus.write_data_M;
               lerr_d  = bad_c | oor_c;
               if (WAIT_CYCLES == 0) begin
                  state_d = S_ACK;
               end else begin
                  state_d = S_WAIT;
                  cnt_d   = CW'(WAIT_CYCLES - 1);
               end
            end
         end
         S_WAIT: begin
            if (!bus.mem_req_M) begin
               state_d = S_IDLE;
            end else if (cnt_q == '0) begin
               state_d = S_ACK;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         S_ACK:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      // Uses the _d view so a zero-wait access commits with the freshly sampled request.
      if (state_d == S_ACK && state_q != S_ACK) begin
         ack_d  = 1'b1;
         merr_d = lerr_d;
         if (lerr_d) begin
            rdata_d = '0;
         end else if (!wr_d) begin
            rdata_d = mem[idx_d];
         end else begin
            mem_we_c = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         wr_q    <= 1'b0;
         be_q    <= '0;
         idx_q   <= '0;
         wdata_q <= '0;
         lerr_q  <= 1'b0;
         rdata_q <= '0;
         ack_q   <= 1'b0;
         merr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         wr_q    <= wr_d;
         be_q    <= be_d;
         idx_q   <= idx_d;
         wdata_q <= wdata_d;
         lerr_q  <= lerr_d;
         rdata_q <= rdata_d;
         ack_q   <= ack_d;
         merr_q  <= merr_d;
      end
   end

   // Storage is never cleared; a reset on the commit edge suppresses the write.
   always_ff @(posedge clk) begin
      if (reset && mem_we_c) begin
         for (int i = 0; i < 4; i++) begin
            if (be_d[i]) mem[idx_d][8*i +: 8] <= wdata_d[8*i +: 8];
         end
      end
   end

   assign bus.read_data_M    = rdata_q;
   assign bus.data_mem_ack_M = ack_q;
   assign bus.mem_err_M      = merr_q;

endmodule
